// File: rtl/ripple_add_sequencer.sv
// ripple_add_sequencer: nibble-serial add/subtract over a shared 4-bit ripple adder
module ripple_adder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] s_o,
    output logic       cout_o
);
    logic [4:0] c;
    // four chained full adders
    always_comb begin
        c = '0;
        s_o = '0;
        c[0] = cin_i;
        for (int i = 0; i < 4; i++) begin
            s_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = c[4];
    end
endmodule

module ripple_add_sequencer #(
    parameter int NIBBLES = 4,
    parameter int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         SUB,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin,
    output logic [W-1:0] S,
    output logic         Cout,
    output logic         V,
    output logic         busy,
    output logic         done
);
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic c_q, c_d, cout_q, cout_d, v_q, v_d;
    logic [3:0] add_s;
    logic add_c, last;

    ripple_adder u_add (
        .a_i   (a_q[4*idx_q +: 4]),
        .b_i   (b_q[4*idx_q +: 4]),
        .cin_i (c_q),
        .s_o   (add_s),
        .cout_o(add_c)
    );

    assign last = idx_q == IW'(NIBBLES - 1);
    assign S    = s_q;
    assign Cout = cout_q;
    assign V    = v_q;
    assign busy = state_q == RUN;
    assign done = state_q == DONE;

    // state and datapath registers; reset discards any partial result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
        end
    end

    // one nibble per RUN cycle; start is only honoured outside RUN
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
        cout_d  = cout_q;
        v_d     = v_q;
        if (state_q == RUN) begin
            s_d[4*idx_q +: 4] = add_s;
            c_d   = add_c;
            idx_d = idx_q + IW'(1);
            if (last) begin
                state_d = DONE;
                cout_d  = add_c;
                v_d     = (a_q[W-1] == b_q[W-1]) && (add_s[3] != a_q[W-1]);
            end
        end else if (start) begin
            state_d = RUN;
            a_d     = A;
            b_d     = SUB ? ~B : B;
            c_d     = SUB | Cin;
            idx_d   = '0;
            s_d     = '0;
            cout_d  = 1'b0;
            v_d     = 1'b0;
        end else begin
            state_d = IDLE;
        end
    end
endmodule
